fifo_drain_arbiter: RTL and testbench



---
 rtl/fifo_drain_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: drains NUM_IN input FIFOs into two output FIFOs chosen by word MSB.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fifo_drain_arbiter #(
  parameter int NUM_IN         = 4,
  parameter int FIFO_WORD_SIZE = 10,
  parameter int FIFO_PTR_SIZE  = 3,
  parameter int AF_DEFAULT     = 6,
  parameter int AE_DEFAULT     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             init,
  input  logic [FIFO_PTR_SIZE-1:0]         almost_full_threshold_input,
  input  logic [FIFO_PTR_SIZE-1:0]         almost_empty_threshold_input,
  input  logic [NUM_IN-1:0]                in_empty,
  input  logic [NUM_IN-1:0]                in_valid,
  input  logic [NUM_IN*FIFO_WORD_SIZE-1:0] in_data,
  input  logic [1:0]                       out_almost_full,
  input  logic [NUM_IN+1:0]                fifo_error,
  output logic [NUM_IN-1:0]                in_rd_en,
  output logic [1:0]                       out_wr_en,
  output logic [FIFO_WORD_SIZE-1:0]        out_data,
  output logic                             fifo_init,
  output logic [FIFO_PTR_SIZE-1:0]         almost_full_threshold,
  output logic [FIFO_PTR_SIZE-1:0]         almost_empty_threshold,
  output logic [4:0]                       state,
  output logic                             idle
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;

  state_t                    state_q, state_d;
  logic                      any_err;
  logic                      grant_found;
  logic [IDX_W-1:0]          grant_idx;
  logic                      pop_en;
  logic                      flush;
  logic                      vld_p1_q;
  logic [IDX_W-1:0]          port_p1_q;
  logic [FIFO_WORD_SIZE-1:0] sel_data;
  logic                      sel_valid;
  logic                      push_d;
  logic [1:0]                out_wr_en_d, out_wr_en_q;
  logic [FIFO_WORD_SIZE-1:0] out_data_q;
  logic [FIFO_PTR_SIZE-1:0]  af_thr_q, ae_thr_q;

  assign any_err = |fifo_error;

`ifdef FIFO_ARB_STRICT_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (!in_empty[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] cand;

  // Search starts one past the last granted port; the power-of-2 width wraps it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand = rr_ptr_q + IDX_W'(i);
      if (!grant_found && !in_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= IDX_W'(NUM_IN - 1);
    end else if (pop_en) begin
      rr_ptr_q <= grant_idx;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   begin
        if (any_err)    state_d = S_ERROR;
        else if (!init) state_d = S_IDLE;
      end
      S_IDLE:   begin
        if (any_err)          state_d = S_ERROR;
        else if (init)        state_d = S_INIT;
        else if (~&in_empty)  state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_err)                       state_d = S_ERROR;
        else if (init)                     state_d = S_INIT;
        else if (&in_empty && !vld_p1_q)   state_d = S_IDLE;
      end
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Stage p0: grant and pop strobe
  assign pop_en = (state_q == S_ACTIVE) && !init && !any_err && grant_found &&
                  (out_almost_full == 2'b00);
  assign flush  = (state_d == S_ERROR);

  always_comb begin
    in_rd_en = '0;
    if (pop_en) in_rd_en[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (pop_en) port_p1_q <= grant_idx;
  end

  // Stage p1: the popped FIFO presents its word; capture and route it
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (port_p1_q == IDX_W'(i)) begin
        sel_data  = in_data[i*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
        sel_valid = in_valid[i];
      end
    end
  end

  assign push_d      = vld_p1_q && sel_valid && !flush;
  assign out_wr_en_d = !push_d ? 2'b00 :
                       (sel_data[FIFO_WORD_SIZE-1] ? 2'b10 : 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      out_wr_en_q <= 2'b00;
      out_data_q  <= '0;
    end else begin
      vld_p1_q    <= pop_en && !flush;
      out_wr_en_q <= out_wr_en_d;
      if (push_d) out_data_q <= sel_data;
    end
  end

  // Stage p2: registered push to the output FIFOs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_thr_q <= FIFO_PTR_SIZE'(AF_DEFAULT);
      ae_thr_q <= FIFO_PTR_SIZE'(AE_DEFAULT);
    end else if (state_q == S_INIT) begin
      af_thr_q <= almost_full_threshold_input;
      ae_thr_q <= almost_empty_threshold_input;
    end
  end

  assign out_wr_en              = out_wr_en_q;
  assign out_data               = out_data_q;
  assign fifo_init              = (state_q == S_INIT);
  assign idle                   = (state_q == S_IDLE);
  assign state                  = state_q;
  assign almost_full_threshold  = af_thr_q;
  assign almost_empty_threshold = ae_thr_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter: queue-based input FIFO models feed the DUT,
// expected pushes are queued at pop time and a negedge monitor checks grants and pushes.
module tb_fifo_drain_arbiter;
  localparam int N = 4;
  localparam int W = 10;
  localparam int P = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             init;
  logic [P-1:0]     af_thr_in, ae_thr_in;
  logic [N-1:0]     in_empty = '1;
  logic [N-1:0]     in_valid = '0;
  logic [N*W-1:0]   in_data  = '0;
  logic [1:0]       out_almost_full;
  logic [N+1:0]     fifo_error;
  logic [N-1:0]     in_rd_en;
  logic [1:0]       out_wr_en;
  logic [W-1:0]     out_data;
  logic             fifo_init;
  logic [P-1:0]     af_thr, ae_thr;
  logic [4:0]       state;
  logic             idle;

  fifo_drain_arbiter #(.NUM_IN(N), .FIFO_WORD_SIZE(W), .FIFO_PTR_SIZE(P),
                       .AF_DEFAULT(6), .AE_DEFAULT(1)) dut (
    .clk(clk), .reset(reset), .init(init),
    .almost_full_threshold_input(af_thr_in), .almost_empty_threshold_input(ae_thr_in),
    .in_empty(in_empty), .in_valid(in_valid), .in_data(in_data),
    .out_almost_full(out_almost_full), .fifo_error(fifo_error),
    .in_rd_en(in_rd_en), .out_wr_en(out_wr_en), .out_data(out_data),
    .fifo_init(fifo_init), .almost_full_threshold(af_thr),
    .almost_empty_threshold(ae_thr), .state(state), .idle(idle));

  always #5 clk = ~clk;

  typedef struct packed { logic v; logic [W-1:0] w; } ent_t;
  typedef struct { int due; logic [1:0] we; logic [W-1:0] d; } exp_t;

  ent_t        fq [N][$];
  exp_t        sb [$];
  int          pop_log [$];
  int          pop_cyc [$];
  logic [11:0] push_log [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          model_ptr = N - 1;
  int          finit_cnt = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Input FIFO model: a pop at cycle N presents its word during N+1.
  always @(posedge clk) begin : fifo_model
    logic [N-1:0] rd;
    ent_t e;
    rd = in_rd_en;
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      if (rd[i]) begin
        chk(fq[i].size() != 0, "pop_of_empty_fifo", 0, 1);
        if (fq[i].size() != 0) begin
          e = fq[i].pop_front();
          in_data[i*W +: W] = e.w;
          in_valid[i] = e.v;
          if (e.v) sb.push_back('{cyc + 1, (e.w[W-1] ? 2'b10 : 2'b01), e.w});
        end
      end
      in_empty[i] = (fq[i].size() == 0);
    end
  end

  always @(negedge clk) if (fifo_init) finit_cnt++;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [N-1:0] ne;
    int exp_port, got_port, p;
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk(out_wr_en == e.we && out_data == e.d && e.due == cyc, "push",
            {out_wr_en, out_data}, {e.we, e.d});
      end else if (out_wr_en != 2'b00) begin
        chk(out_wr_en == 2'b00, "unexpected_push", out_wr_en, 0);
      end
      if (out_wr_en != 2'b00) push_log.push_back({out_wr_en, out_data});

      ne = ~in_empty;
      if (in_rd_en != '0) begin
        chk($onehot(in_rd_en), "rd_onehot", in_rd_en, 0);
        chk(out_almost_full == 2'b00 && !init && fifo_error == '0, "pop_gating",
            {out_almost_full, init}, 0);
        exp_port = -1;
`ifdef FIFO_ARB_STRICT_PRIO_EN
        for (int i = 0; i < N; i++) if (exp_port < 0 && ne[i]) exp_port = i;
`else
        for (int k = 1; k <= N; k++) begin
          p = (model_ptr + k) % N;
          if (exp_port < 0 && ne[p]) exp_port = p;
        end
`endif
        got_port = -1;
        for (int i = 0; i < N; i++) if (in_rd_en[i]) got_port = i;
        chk(got_port == exp_port, "grant_order", got_port, exp_port);
        model_ptr = got_port;
        pop_log.push_back(got_port);
        pop_cyc.push_back(cyc);
      end else if (state == 5'b01000 && !init && out_almost_full == 2'b00 &&
                   fifo_error == '0 && ne != '0) begin
        chk(in_rd_en != '0, "pop_missing", in_rd_en, ne);
      end
    end
  end

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += fq[i].size();
    return s;
  endfunction

  task automatic wait_drain(input int maxc);
    int k = 0;
    @(negedge clk);
    while (k < maxc && !(sb.size() == 0 && pending() == 0 && in_empty == '1 && idle)) begin
      @(negedge clk);
      k++;
    end
    chk(k < maxc, "drain_timeout", k, maxc);
  endtask

  task automatic load(input int port, input logic v, input logic [W-1:0] w);
    fq[port].push_back('{v, w});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk(state == 5'b00001, "rst_state", state, 5'b00001);
    chk(out_wr_en == 2'b00 && in_rd_en == '0, "rst_strobes", {out_wr_en, in_rd_en}, 0);
    chk(out_data == '0, "rst_out_data", out_data, 0);
    chk(!fifo_init && !idle, "rst_init_idle", {fifo_init, idle}, 0);
    chk(af_thr == 3'd6 && ae_thr == 3'd1, "rst_thresholds", {af_thr, ae_thr}, {3'd6, 3'd1});
    sb.delete();
    for (int i = 0; i < N; i++) fq[i].delete();
    model_ptr = N - 1;
    init = 1'b0;
    fifo_error = '0;
    out_almost_full = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1 chk(state == 5'b00010, "post_rst_init", state, 5'b00010);
    @(posedge clk);
    #1 chk(state == 5'b00100, "post_rst_idle", state, 5'b00100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord [8];
    int af_pops, k, port;
    reset = 1'b1; init = 1'b1; af_thr_in = 3'd5; ae_thr_in = 3'd2;
    out_almost_full = 2'b00; fifo_error = '0;
    repeat (2) @(posedge clk);
    #3;
    chk(state == 5'b00001, "reset_state", state, 5'b00001);
    chk(in_rd_en == '0 && out_wr_en == 2'b00 && out_data == '0, "reset_outputs",
        {in_rd_en, out_wr_en, out_data}, 0);
    chk(!fifo_init && !idle, "reset_init_idle", {fifo_init, idle}, 0);
    chk(af_thr == 3'd6 && ae_thr == 3'd1, "reset_thresholds", {af_thr, ae_thr}, {3'd6, 3'd1});

    // Threshold load: init held through RESET and two INIT cycles
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 init = 1'b0;
    @(posedge clk);
    #1;
    chk(state == 5'b00100, "init_exit_idle", state, 5'b00100);
    chk(af_thr == 3'd5 && ae_thr == 3'd2, "init_thresholds", {af_thr, ae_thr}, {3'd5, 3'd2});
    chk(finit_cnt == 3, "fifo_init_cycles", finit_cnt, 3);

    // Arbitration order with two words on every port
`ifdef FIFO_ARB_STRICT_PRIO_EN
    exp_ord = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    pop_log.delete(); pop_cyc.delete();
    @(posedge clk); #3;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) load(i, 1'b1, W'($urandom));
    wait_drain(200);
    chk(pop_log.size() == 8, "order_pop_count", pop_log.size(), 8);
    if (pop_log.size() == 8)
      for (int i = 0; i < 8; i++) begin
        chk(pop_log[i] == exp_ord[i], "order_port", pop_log[i], exp_ord[i]);
        chk(pop_cyc[i] == pop_cyc[0] + i, "order_back_to_back", pop_cyc[i], pop_cyc[0] + i);
      end

    // MSB routing from port 2
    push_log.delete();
    @(posedge clk); #3;
    load(2, 1'b1, 10'h2A5);
    load(2, 1'b1, 10'h0A5);
    wait_drain(100);
    chk(push_log.size() == 2, "route_count", push_log.size(), 2);
    if (push_log.size() == 2) begin
      chk(push_log[0] == {2'b10, 10'h2A5}, "route_first", push_log[0], {2'b10, 10'h2A5});
      chk(push_log[1] == {2'b01, 10'h0A5}, "route_second", push_log[1], {2'b01, 10'h0A5});
    end

    // Word that vanished before its pop returned: no push
    push_log.delete();
    @(posedge clk); #3;
    load(0, 1'b0, 10'h3FF);
    load(0, 1'b1, 10'h155);
    wait_drain(100);
    chk(push_log.size() == 1, "ghost_count", push_log.size(), 1);
    if (push_log.size() == 1)
      chk(push_log[0] == {2'b01, 10'h155}, "ghost_word", push_log[0], {2'b01, 10'h155});

    // Backpressure from output FIFO 1 for four cycles
    @(posedge clk); #3;
    out_almost_full = 2'b10;
    load(1, 1'b1, 10'h011); load(1, 1'b1, 10'h212); load(3, 1'b1, 10'h033);
    af_pops = 0;
    repeat (4) begin
      @(negedge clk);
      if (in_rd_en != '0) af_pops++;
    end
    chk(af_pops == 0, "af_no_pops", af_pops, 0);
    @(posedge clk); #3 out_almost_full = 2'b00;
    @(negedge clk);
    chk(in_rd_en != '0, "af_resume", in_rd_en, 1);
    wait_drain(100);

    // init raised while draining: INIT entered, in-flight words still pushed
    @(posedge clk); #3;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++) load(i, 1'b1, W'($urandom));
    repeat (4) @(posedge clk);
    #3 init = 1'b1;
    @(posedge clk); #1;
    chk(state == 5'b00010 && fifo_init, "active_to_init", {state, fifo_init}, {5'b00010, 1'b1});
    repeat (2) @(posedge clk);
    #3 init = 1'b0;
    wait_drain(200);

    // Error while active: sticky ERROR, all strobes low
    @(posedge clk); #3;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) load(i, 1'b1, W'($urandom));
    k = 0;
    do begin @(negedge clk); k++; end while (in_rd_en == '0 && k < 20);
    chk(k < 20, "err_wait_pop", k, 20);
    @(posedge clk); #3 fifo_error[5] = 1'b1;
    @(posedge clk); #2;
    sb.delete();
    fifo_error = '0;
    init = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk(state == 5'b10000, "err_state", state, 5'b10000);
      chk(in_rd_en == '0 && out_wr_en == 2'b00 && !fifo_init, "err_strobes",
          {in_rd_en, out_wr_en, fifo_init}, 0);
    end
    do_reset();

    // Reset pulsed mid-stream clears outputs without a clock edge
    @(posedge clk); #3;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++) load(i, 1'b1, W'($urandom) | W'(1));
    k = 0;
    do begin @(negedge clk); k++; end while (out_wr_en == 2'b00 && k < 20);
    chk(k < 20, "midrst_wait_push", k, 20);
    do_reset();
    wait_drain(100);

    // Randomized traffic with backpressure, init pulses and invalid returns
    push_log.delete();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #3;
      if ($urandom_range(0, 2) == 0) begin
        port = $urandom_range(0, N - 1);
        load(port, ($urandom_range(0, 7) != 0), W'($urandom));
      end
      out_almost_full = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      init = ($urandom_range(0, 39) == 0);
      af_thr_in = P'($urandom);
      ae_thr_in = P'($urandom);
    end
    @(posedge clk); #3;
    out_almost_full = 2'b00;
    init = 1'b0;
    wait_drain(2000);
    chk(push_log.size() > 50, "random_activity", push_log.size(), 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
